stage2_conv_sched: RTL
======================

// Module: stage2_conv_sched
// PURPOSE
//  Sequences the Stage2 convolution datapath (3-CI, 5x5, 7-cycle CI accumulator).
//  Accepts one CI x 5x5 window per handshake and replays it over CO output channels.
//  For each channel it drives a weight-bank select and an issue strobe.
//  Tags returning results, then buffers them in a result FIFO with a valid/ready output.
//  Credit control: the non-stallable accumulator pipeline can never overflow that FIFO.
// PARAMETERS
//  CO         4          output channels replayed per window
//  N_WIN      64         windows per frame
//  LATENCY    7          accumulator issue-to-result latency, cycles
//  FIFO_DEPTH 8          result FIFO entries; must be >= LATENCY+1
//  DW         `ACI_BW    result data width
// PORTS
//  clk         in   1               clock
//  reset_n     in   1               asynchronous, active-low reset
//  i_start     in   1               frame start pulse
//  i_win_valid in   1               window buffer has a window
//  o_win_ready out  1               window accepted when valid&ready
//  o_fmap_hold out  1               datapath holds the latched window
//  o_acc_valid out  1               issue strobe to accumulator i_in_valid
//  o_w_sel     out  $clog2(CO)      weight bank select, valid with o_acc_valid
//  i_acc_valid in   1               accumulator o_ot_valid
//  i_acc_data  in   DW              accumulator o_ot_ci_acc
//  o_res_valid out  1               result available
//  i_res_ready in   1               downstream accepts result
//  o_res_data  out  DW              result
//  o_res_co    out  $clog2(CO)      output channel of result
//  o_res_last  out  1               final result of frame
//  o_busy      out  1               state != IDLE
//  o_done      out  1               one-cycle pulse at frame end
//  o_err       out  1               sticky tag/valid mismatch
// BEHAVIOUR
//  - Reset: state=IDLE, all counters/FIFO cleared, every output 0 (incl. o_err).
//  - FSM IDLE->WAIT_WIN on i_start; win_cnt=0. i_start in other states ignored.
//  - WAIT_WIN: o_win_ready=1; on i_win_valid -> ISSUE, co_cnt=0.
//  - ISSUE: o_fmap_hold=1, o_win_ready=0.
//    - Each cycle with credit: o_acc_valid=1, o_w_sel=co_cnt, co_cnt++.
//    - No credit: o_acc_valid=0, counters hold.
//    - After issuing co_cnt=CO-1: if win_cnt==N_WIN-1 go DRAIN, else win_cnt++ and go WAIT_WIN.
//  - DRAIN: wait until inflight==0 -> DONE. DONE: o_done=1 one cycle -> IDLE.
//  - Credit: inflight = issued - popped. Issue only if inflight < FIFO_DEPTH.
//    A pop in the same cycle grants no credit (conservative).
//  - Tag pipe: LATENCY-deep shift of {valid, co, last}, loaded at issue.
//    At the output, the tag pushes {i_acc_data, co, last} into the FIFO.
//  - Any cycle where tag valid != i_acc_valid sets o_err. o_err stays set until reset.
//    Push is driven by the tag, not by i_acc_valid.
//  - last=1 only for the CO-1 issue of window N_WIN-1.
//  - FIFO: registered outputs; entry visible on o_res_valid the cycle after push.
//    Pop on o_res_valid & i_res_ready; push+pop in the same cycle allowed.
//    Overflow is impossible by credit; pop when empty is a no-op.
//  - o_res_data/co/last hold while o_res_valid & !i_res_ready.
//  - Issue-to-o_res_valid = LATENCY+1 cycles with an empty FIFO.
//  - Mid-frame reset: all in-flight tags and FIFO contents discarded.
// TESTING
//  1. CO=4,N_WIN=2, ready=1:
//     o_w_sel 0,1,2,3,(win2)0,1,2,3; 8 results in order.
//     First o_res_valid 8 cycles after first issue; o_res_last on the 8th result; o_done follows.
//  2. i_res_ready=0 from start:
//     exactly 8 issues then o_acc_valid stalls. Raise ready -> issues resume.
//     All results delivered in order, none lost or duplicated.
//  3. i_win_valid withheld 20 cycles after the first window:
//     FSM in WAIT_WIN, o_acc_valid=0 throughout; resumes on valid.
//  4. Inject i_acc_valid=1 with an empty tag pipe:
//     o_err=1 next cycle and stays set; FIFO count unchanged.
//  5. Assert reset_n=0 during ISSUE of window 3:
//     all outputs 0. A new i_start then runs a clean frame with correct co/last.
//  6. Pulse i_start during ISSUE: ignored, win_cnt unaffected, single o_done at frame end.

Source files
------------

// File: rtl/stage2_conv_sched.sv
// stage2_conv_sched: replays each CI window over CO weight banks, tags the fixed-latency
// accumulator results and queues them in a credit-protected result FIFO.
`ifndef ACI_BW
`define ACI_BW 16
`endif
module stage2_conv_sched #(
   parameter int CO         = 4,
   parameter int N_WIN      = 64,
   parameter int LATENCY    = 7,
   parameter int FIFO_DEPTH = 8,
   parameter int DW         = `ACI_BW
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_start,
   input  logic          i_win_valid,
   output logic          o_win_ready,
   output logic          o_fmap_hold,
   output logic          o_acc_valid,
   output logic [((CO > 1) ? $clog2(CO) : 1)-1:0] o_w_sel,
   input  logic          i_acc_valid,
   input  logic [DW-1:0] i_acc_data,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [DW-1:0] o_res_data,
   output logic [((CO > 1) ? $clog2(CO) : 1)-1:0] o_res_co,
   output logic          o_res_last,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);
   localparam int CW = (CO > 1) ? $clog2(CO) : 1;
   localparam int WW = (N_WIN > 1) ? $clog2(N_WIN) : 1;
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = CW + 2;
   localparam int EW = DW + CW + 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_co;
   logic [WW-1:0]   r_win;
   logic [FW-1:0]   r_inflight;
   logic            r_err;
   logic [TW-1:0]   r_tag [LATENCY];
   logic [EW-1:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wp, r_rp;
   logic [FW-1:0]   r_cnt;

   logic            w_credit, w_issue, w_co_end, w_win_end, w_push, w_pop;
   logic [TW-1:0]   w_tag_out;

   assign w_credit  = r_inflight < FW'(FIFO_DEPTH);
   assign w_issue   = (r_state == S_ISSUE) && w_credit;
   assign w_co_end  = r_co == CW'(CO - 1);
   assign w_win_end = r_win == WW'(N_WIN - 1);
   assign w_tag_out = r_tag[LATENCY-1];
   assign w_push    = w_tag_out[TW-1];
   assign w_pop     = o_res_valid && i_res_ready;

   assign o_w_sel     = o_acc_valid ? r_co : '0;
   assign o_busy      = r_state != S_IDLE;
   assign o_err       = r_err;
   assign o_res_valid = r_cnt != '0;
   assign {o_res_data, o_res_co, o_res_last} = o_res_valid ? r_mem[r_rp] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_win_ready = 1'b0;
      o_fmap_hold = 1'b0;
      o_acc_valid = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE:  w_next = i_start ? S_WAIT : S_IDLE;
         S_WAIT: begin
            o_win_ready = 1'b1;
            w_next      = i_win_valid ? S_ISSUE : S_WAIT;
         end
         S_ISSUE: begin
            o_fmap_hold = 1'b1;
            o_acc_valid = w_credit;
            w_next      = !(w_credit && w_co_end) ? S_ISSUE : w_win_end ? S_DRAIN : S_WAIT;
         end
         S_DRAIN: w_next = (r_inflight == '0) ? S_DONE : S_DRAIN;
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // inflight covers both the accumulator pipe and the FIFO; a same-cycle pop is not counted as credit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_co       <= '0;
         r_win      <= '0;
         r_inflight <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_start) r_win <= '0;
         if (r_state == S_WAIT && i_win_valid) r_co <= '0;
         if (w_issue) begin
            r_co <= w_co_end ? '0 : r_co + CW'(1);
            if (w_co_end && !w_win_end) r_win <= r_win + WW'(1);
         end
         r_inflight <= r_inflight + FW'(w_issue) - FW'(w_pop);
         if (w_push != i_acc_valid) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= {w_issue, r_co, w_issue && w_co_end && w_win_end};
         for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {i_acc_data, w_tag_out[TW-2:0]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + PW'(1);
         if (w_pop)  r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + PW'(1);
         r_cnt <= r_cnt + FW'(w_push) - FW'(w_pop);
      end
   end
endmodule
